i2s_receiver: RTL

//  Deserialises an I2S (Philips) stream from the codec ADC: frame_clk, bit_clk, sdata.

---
 rtl/i2s_receiver_if.sv | 22 ++
 rtl/i2s_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver_if.sv
// Sample-pair stream between the I2S receiver and its consumer.
// The receiver drives out_valid, the sample pair and the overflow pulse.
// The consumer drives out_ready.
interface i2s_receiver_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    out_valid;
  logic                    out_ready;
  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    overflow;

  modport master (
    output out_valid, sample_left, sample_right, overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid, sample_left, sample_right, overflow,
    output out_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S (Philips) receiver.
// Deserialises frame_clk/bit_clk/sdata from the codec ADC and delivers
// left/right pairs on a valid/ready stream in the clk domain.
// Optional feature: define I2S_RX_PEAK_EN to build the per-channel peak meters.
// Without the macro, o_peak_left and o_peak_right are tied to 0 and
// i_peak_clear is ignored.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic                    i_bit_clk,
  input  logic                    i_frame_clk,
  input  logic                    i_sdata,
  input  logic                    i_peak_clear,
  output logic [SAMPLE_WIDTH-1:0] o_peak_left,
  output logic [SAMPLE_WIDTH-1:0] o_peak_right,
  i2s_receiver_if.master          o_pair
);

  localparam logic [CNT_WIDTH-1:0] LP_W = CNT_WIDTH'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {
    S_SYNC,
    S_LEFT,
    S_RIGHT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_bclk_sync;
  logic [1:0]              r_ws_sync;
  logic [1:0]              r_sd_sync;
  logic                    r_bclk_prev;
  logic                    r_ws_prev;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_left_hold;
  logic                    r_out_valid;
  logic [SAMPLE_WIDTH-1:0] r_sample_left;
  logic [SAMPLE_WIDTH-1:0] r_sample_right;
  logic                    r_overflow;

  logic                    w_bit_evt;
  logic                    w_ws;
  logic                    w_sd;
  logic                    w_boundary;
  logic                    w_room;
  logic [SAMPLE_WIDTH-1:0] w_shift_next;
  logic [CNT_WIDTH-1:0]    w_cnt_next;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic                    w_latch_left;
  logic                    w_publish;
  logic                    w_load;

  // The bit event uses the synchronised bit_clk level together with the
  // level it had one clk earlier, so only the rising edge fires.
  assign w_bit_evt  = r_bclk_sync[1] & ~r_bclk_prev;
  assign w_ws       = r_ws_sync[1];
  assign w_sd       = r_sd_sync[1];
  assign w_boundary = w_bit_evt & (w_ws != r_ws_prev);

  // The boundary bit is still the LSB of the ending word.
  // The completed word therefore comes from the post-shift value.
  // It is left-aligned so that short slots fill the top bits.
  assign w_room       = (r_cnt < LP_W);
  assign w_shift_next = w_room ? {r_shift[SAMPLE_WIDTH-2:0], w_sd} : r_shift;
  assign w_cnt_next   = w_room ? (r_cnt + CNT_WIDTH'(1)) : r_cnt;
  assign w_word       = w_shift_next << (LP_W - w_cnt_next);

  // Pin synchronisers, bit_clk edge history and word-select history.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of the others; blocking here would collapse
  // the 2-flop synchronisers into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_ws_sync   <= '0;
      r_sd_sync   <= '0;
      r_bclk_prev <= 1'b0;
      r_ws_prev   <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], i_bit_clk};
      r_ws_sync   <= {r_ws_sync[0], i_frame_clk};
      r_sd_sync   <= {r_sd_sync[0], i_sdata};
      r_bclk_prev <= r_bclk_sync[1];
      if (w_bit_evt) begin
        r_ws_prev <= w_ws;
      end
    end
  end

  // Slot shift register and bit counter. Both clear at every word boundary,
  // and the partial word is dropped while the receiver is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!i_enable) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_bit_evt) begin
      if (w_boundary) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_shift <= w_shift_next;
        r_cnt   <= w_cnt_next;
      end
    end
  end

  // Frame-alignment state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and control strobes.
  // An unexpected boundary direction means alignment was lost, so the FSM
  // returns to S_SYNC.
  // NOTE: every output of this block is given a default first so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_latch_left = 1'b0;
    w_publish    = 1'b0;
    if (!i_enable) begin
      w_state_next = S_SYNC;
    end else if (w_boundary) begin
      case (r_state)
        S_SYNC: begin
          if (r_ws_prev) begin
            w_state_next = S_LEFT;
          end
        end
        S_LEFT: begin
          if (!r_ws_prev) begin
            w_latch_left = 1'b1;
            w_state_next = S_RIGHT;
          end else begin
            w_state_next = S_SYNC;
          end
        end
        S_RIGHT: begin
          if (r_ws_prev) begin
            w_publish    = 1'b1;
            w_state_next = S_LEFT;
          end else begin
            w_state_next = S_SYNC;
          end
        end
        default: w_state_next = S_SYNC;
      endcase
    end
  end

  // Holds the left word until its right partner arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left_hold <= '0;
    end else if (w_latch_left) begin
      r_left_hold <= w_word;
    end
  end

  // A completed pair loads only into a free output slot, or into a slot that
  // is being accepted in the same cycle. Otherwise the pair is dropped.
  assign w_load = w_publish & (~r_out_valid | o_pair.out_ready);

  // Output pair register, valid flag and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_load) begin
        r_out_valid    <= 1'b1;
        r_sample_left  <= r_left_hold;
        r_sample_right <= w_word;
      end else if (w_publish) begin
        r_overflow <= 1'b1;
      end else if (r_out_valid && o_pair.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_pair.out_valid    = r_out_valid;
  assign o_pair.sample_left  = r_sample_left;
  assign o_pair.sample_right = r_sample_right;
  assign o_pair.overflow     = r_overflow;

`ifdef I2S_RX_PEAK_EN
  logic [SAMPLE_WIDTH-1:0] r_peak_left;
  logic [SAMPLE_WIDTH-1:0] r_peak_right;
  logic [SAMPLE_WIDTH-1:0] w_abs_left;
  logic [SAMPLE_WIDTH-1:0] w_abs_right;

  // Magnitude of a two's-complement sample. The most negative code saturates
  // to the largest positive code so that the result stays in range.
  function automatic logic [SAMPLE_WIDTH-1:0] f_abs_sat(input logic [SAMPLE_WIDTH-1:0] s);
    if (!s[SAMPLE_WIDTH-1]) begin
      return s;
    end else if (s == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}) begin
      return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      return -s;
    end
  endfunction

  assign w_abs_left  = f_abs_sat(r_left_hold);
  assign w_abs_right = f_abs_sat(w_word);

  // Peak meters follow the pairs that actually load. A clear beats a
  // simultaneous update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak_left  <= '0;
      r_peak_right <= '0;
    end else if (i_peak_clear) begin
      r_peak_left  <= '0;
      r_peak_right <= '0;
    end else if (w_load) begin
      if (w_abs_left > r_peak_left) begin
        r_peak_left <= w_abs_left;
      end
      if (w_abs_right > r_peak_right) begin
        r_peak_right <= w_abs_right;
      end
    end
  end

  assign o_peak_left  = r_peak_left;
  assign o_peak_right = r_peak_right;
`else
  logic w_unused_peak_clear;

  assign w_unused_peak_clear = i_peak_clear;
  assign o_peak_left         = '0;
  assign o_peak_right        = '0;
`endif

endmodule
